// File: rtl/vdd_1v8_rail_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : vdd_1v8_rail_sequencer_if
// Brief   : Control/status bundle between the board power logic and the
//           1V8 rail sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface vdd_1v8_rail_sequencer_if;
  logic       int_1ms_en;
  logic       power_on_req;
  logic       pg_vdd_1v8_raw;
  logic       en_vdd_1v8;
  logic       pg_vdd_1v8;
  logic       rail_fault;
  logic [1:0] retry_count;
  logic [2:0] seq_state;

  modport master (
    output int_1ms_en,
    output power_on_req,
    output pg_vdd_1v8_raw,
    input  en_vdd_1v8,
    input  pg_vdd_1v8,
    input  rail_fault,
    input  retry_count,
    input  seq_state
  );

  modport slave (
    input  int_1ms_en,
    input  power_on_req,
    input  pg_vdd_1v8_raw,
    output en_vdd_1v8,
    output pg_vdd_1v8,
    output rail_fault,
    output retry_count,
    output seq_state
  );
endinterface
`default_nettype wire

// File: rtl/vdd_1v8_rail_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : vdd_1v8_rail_sequencer
// Brief   : Enables the 1V8 rail, debounces its power-good, handles ramp
//           timeout, brown-out and bounded retry with a latched fault.
// Revision: 1.0 - initial release
// ============================================================================
module vdd_1v8_rail_sequencer #(
  parameter int unsigned DEBOUNCE_MS   = 5,
  parameter int unsigned PG_TIMEOUT_MS = 50,
  parameter int unsigned DROP_MS       = 2,
  parameter int unsigned OFF_DWELL_MS  = 20,
  parameter int unsigned RETRY_MAX     = 3
) (
  input  wire logic                 clock,
  input  wire logic                 reset,
  vdd_1v8_rail_sequencer_if.slave   rail
);

  localparam logic [7:0] c_DEBOUNCE  = 8'(DEBOUNCE_MS);
  localparam logic [7:0] c_TIMEOUT   = 8'(PG_TIMEOUT_MS);
  localparam logic [7:0] c_DROP      = 8'(DROP_MS);
  localparam logic [7:0] c_DWELL     = 8'(OFF_DWELL_MS);
  localparam logic [1:0] c_RETRY_MAX = 2'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP      = 3'd1,
    S_GOOD      = 3'd2,
    S_DISCHARGE = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     r_state;
  logic       r_pg_meta;
  logic       r_pg_sync;
  logic [7:0] r_debounce_cnt;
  logic [7:0] r_timeout_cnt;
  logic [7:0] r_drop_cnt;
  logic [7:0] r_dwell_cnt;
  logic [1:0] r_retry;
  logic       r_en;
  logic       r_pg;
  logic       r_fault;

  logic [7:0] w_debounce_nxt;
  logic [7:0] w_timeout_nxt;
  logic [7:0] w_drop_nxt;
  logic [7:0] w_dwell_nxt;
  logic [1:0] w_retry_inc;

  // Candidate counter values for the current tick; the FSM commits them only on ticks.
  assign w_debounce_nxt = r_pg_sync ? f_sat_inc(r_debounce_cnt) : 8'd0;
  assign w_timeout_nxt  = f_sat_inc(r_timeout_cnt);
  assign w_drop_nxt     = r_pg_sync ? 8'd0 : f_sat_inc(r_drop_cnt);
  assign w_dwell_nxt    = f_sat_inc(r_dwell_cnt);
  assign w_retry_inc    = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_OFF;
      r_pg_meta      <= 1'b0;
      r_pg_sync      <= 1'b0;
      r_debounce_cnt <= 8'd0;
      r_timeout_cnt  <= 8'd0;
      r_drop_cnt     <= 8'd0;
      r_dwell_cnt    <= 8'd0;
      r_retry        <= 2'd0;
      r_en           <= 1'b0;
      r_pg           <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_pg_meta <= rail.pg_vdd_1v8_raw;
      r_pg_sync <= r_pg_meta;

      // Moore outputs decoded from the state held before this edge.
      r_en    <= (r_state == S_RAMP) || (r_state == S_GOOD);
      r_pg    <= (r_state == S_GOOD);
      r_fault <= (r_state == S_FAULT);

      case (r_state)
        S_OFF: begin
          r_retry <= 2'd0;
          if (rail.power_on_req) begin
            r_state        <= S_RAMP;
            r_debounce_cnt <= 8'd0;
            r_timeout_cnt  <= 8'd0;
          end
        end

        S_RAMP: begin
          if (!rail.power_on_req) begin
            r_state     <= S_DISCHARGE;
            r_dwell_cnt <= 8'd0;
          end else if (rail.int_1ms_en) begin
            r_debounce_cnt <= w_debounce_nxt;
            r_timeout_cnt  <= w_timeout_nxt;
            if (w_debounce_nxt >= c_DEBOUNCE) begin
              r_state    <= S_GOOD;
              r_drop_cnt <= 8'd0;
            end else if (w_timeout_nxt >= c_TIMEOUT) begin
              r_state     <= S_DISCHARGE;
              r_dwell_cnt <= 8'd0;
              r_retry     <= w_retry_inc;
            end
          end
        end

        S_GOOD: begin
          if (!rail.power_on_req) begin
            r_state     <= S_DISCHARGE;
            r_dwell_cnt <= 8'd0;
          end else if (rail.int_1ms_en) begin
            r_drop_cnt <= w_drop_nxt;
            if (w_drop_nxt >= c_DROP) begin
              r_state     <= S_DISCHARGE;
              r_dwell_cnt <= 8'd0;
              r_retry     <= w_retry_inc;
            end
          end
        end

        S_DISCHARGE: begin
          // The dwell is served in full regardless of request changes.
          if (rail.int_1ms_en) begin
            r_dwell_cnt <= w_dwell_nxt;
            if (w_dwell_nxt >= c_DWELL) begin
              if (!rail.power_on_req) begin
                r_state <= S_OFF;
                r_retry <= 2'd0;
              end else if (r_retry >= c_RETRY_MAX) begin
                r_state <= S_FAULT;
              end else begin
                r_state        <= S_RAMP;
                r_debounce_cnt <= 8'd0;
                r_timeout_cnt  <= 8'd0;
              end
            end
          end
        end

        S_FAULT: begin
          if (!rail.power_on_req) begin
            r_state <= S_OFF;
            r_retry <= 2'd0;
          end
        end

        default: begin
          r_state <= S_OFF;
        end
      endcase
    end
  end

  assign rail.en_vdd_1v8  = r_en;
  assign rail.pg_vdd_1v8  = r_pg;
  assign rail.rail_fault  = r_fault;
  assign rail.retry_count = r_retry;
  assign rail.seq_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vdd_1v8_rail_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vdd_1v8_rail_sequencer
// Brief   : Directed plus randomized bench with a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vdd_1v8_rail_sequencer;

  localparam int c_TICK_DIV = 4;
  localparam int c_OFF = 0, c_RAMP = 1, c_GOOD = 2, c_DIS = 3, c_FAULT = 4;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  vdd_1v8_rail_sequencer_if rail_if ();

  vdd_1v8_rail_sequencer dut (
    .clock (clock),
    .reset (reset),
    .rail  (rail_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: phase plus elapsed-tick tallies, written from the rail rules.
  int m_state = 0, m_deb = 0, m_to = 0, m_drop = 0, m_dwell = 0, m_retry = 0;
  bit m_s1 = 0, m_s2 = 0, m_en = 0, m_pg = 0, m_fault = 0;

  task automatic go_discharge(input bit count_failure);
    m_state = c_DIS;
    m_dwell = 0;
    if (count_failure) m_retry = (m_retry < 3) ? m_retry + 1 : 3;
  endtask

  task automatic model_edge(input bit rst_i, input bit tick, input bit req, input bit raw);
    bit pg;
    pg = m_s2;
    if (rst_i) begin
      m_state = c_OFF; m_deb = 0; m_to = 0; m_drop = 0; m_dwell = 0; m_retry = 0;
      m_s1 = 0; m_s2 = 0; m_en = 0; m_pg = 0; m_fault = 0;
      return;
    end
    m_en    = (m_state == c_RAMP) || (m_state == c_GOOD);
    m_pg    = (m_state == c_GOOD);
    m_fault = (m_state == c_FAULT);
    m_s2 = m_s1;
    m_s1 = raw;
    if (m_state == c_OFF) begin
      m_retry = 0;
      if (req) begin m_state = c_RAMP; m_deb = 0; m_to = 0; end
    end else if (m_state == c_RAMP) begin
      if (!req) go_discharge(0);
      else if (tick) begin
        m_to++;
        m_deb = pg ? m_deb + 1 : 0;
        if (m_deb >= 5) begin m_state = c_GOOD; m_drop = 0; end
        else if (m_to >= 50) go_discharge(1);
      end
    end else if (m_state == c_GOOD) begin
      if (!req) go_discharge(0);
      else if (tick) begin
        m_drop = pg ? 0 : m_drop + 1;
        if (m_drop >= 2) go_discharge(1);
      end
    end else if (m_state == c_DIS) begin
      if (tick) begin
        m_dwell++;
        if (m_dwell >= 20) begin
          if (!req) begin m_state = c_OFF; m_retry = 0; end
          else if (m_retry >= 3) m_state = c_FAULT;
          else begin m_state = c_RAMP; m_deb = 0; m_to = 0; end
        end
      end
    end else begin
      if (!req) begin m_state = c_OFF; m_retry = 0; end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    rail_if.int_1ms_en = ((cyc % c_TICK_DIV) == 0);
    cyc++;
    model_edge(reset, rail_if.int_1ms_en, rail_if.power_on_req, rail_if.pg_vdd_1v8_raw);
    @(posedge clock);
    @(negedge clock);
    chk("seq_state",   {5'd0, rail_if.seq_state},   8'(m_state));
    chk("retry_count", {6'd0, rail_if.retry_count}, 8'(m_retry));
    chk("en_vdd_1v8",  {7'd0, rail_if.en_vdd_1v8},  {7'd0, m_en});
    chk("pg_vdd_1v8",  {7'd0, rail_if.pg_vdd_1v8},  {7'd0, m_pg});
    chk("rail_fault",  {7'd0, rail_if.rail_fault},  {7'd0, m_fault});
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n * c_TICK_DIV; i++) step();
  endtask

  initial begin
    int hold;
    bit reached;
    reset = 1'b1;
    rail_if.int_1ms_en     = 1'b0;
    rail_if.power_on_req   = 1'b0;
    rail_if.pg_vdd_1v8_raw = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    step();
    chk("reset_state", {5'd0, rail_if.seq_state}, 8'd0);
    chk("reset_en", {7'd0, rail_if.en_vdd_1v8}, 8'd0);

    // Normal power-up: PG rises three ticks after enable
    rail_if.power_on_req = 1'b1;
    step();
    run_ticks(3);
    rail_if.pg_vdd_1v8_raw = 1'b1;
    run_ticks(8);
    chk("normal_pg", {7'd0, rail_if.pg_vdd_1v8}, 8'd1);
    chk("normal_retry", {6'd0, rail_if.retry_count}, 8'd0);
    chk("normal_fault", {7'd0, rail_if.rail_fault}, 8'd0);

    // One-tick glitch is filtered
    rail_if.pg_vdd_1v8_raw = 1'b0;
    run_ticks(1);
    rail_if.pg_vdd_1v8_raw = 1'b1;
    run_ticks(3);
    chk("glitch1_pg", {7'd0, rail_if.pg_vdd_1v8}, 8'd1);

    // Two-tick low is a brown-out
    rail_if.pg_vdd_1v8_raw = 1'b0;
    run_ticks(2);
    rail_if.pg_vdd_1v8_raw = 1'b1;
    run_ticks(1);
    chk("brownout_state", {5'd0, rail_if.seq_state}, 8'd3);
    chk("brownout_en", {7'd0, rail_if.en_vdd_1v8}, 8'd0);
    chk("brownout_retry", {6'd0, rail_if.retry_count}, 8'd1);
    run_ticks(30);
    chk("recover_good", {5'd0, rail_if.seq_state}, 8'd2);

    // Shutdown from GOOD, then a request during dwell
    rail_if.power_on_req = 1'b0;
    step();
    step();
    chk("shutdown_en", {7'd0, rail_if.en_vdd_1v8}, 8'd0);
    run_ticks(22);
    chk("shutdown_off", {5'd0, rail_if.seq_state}, 8'd0);
    chk("shutdown_retry", {6'd0, rail_if.retry_count}, 8'd0);
    rail_if.power_on_req = 1'b1;
    run_ticks(8);
    rail_if.power_on_req = 1'b0;
    run_ticks(5);
    rail_if.power_on_req = 1'b1;
    run_ticks(17);
    chk("redwell_ramp", {5'd0, rail_if.seq_state}, 8'd1);
    run_ticks(8);
    rail_if.power_on_req = 1'b0;
    run_ticks(25);

    // Debounce completes on the same tick as the timeout
    rail_if.pg_vdd_1v8_raw = 1'b0;
    rail_if.power_on_req   = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      step();
      reached = (m_state == c_RAMP) && (m_to == 45);
    end
    chk("simul_wait", {7'd0, reached}, 8'd1);
    rail_if.pg_vdd_1v8_raw = 1'b1;
    run_ticks(6);
    chk("simul_good", {5'd0, rail_if.seq_state}, 8'd2);
    chk("simul_retry", {6'd0, rail_if.retry_count}, 8'd0);
    rail_if.power_on_req = 1'b0;
    run_ticks(25);

    // Repeated ramp timeouts end in a latched fault
    rail_if.pg_vdd_1v8_raw = 1'b0;
    rail_if.power_on_req   = 1'b1;
    run_ticks(215);
    chk("fault_state", {5'd0, rail_if.seq_state}, 8'd4);
    chk("fault_flag", {7'd0, rail_if.rail_fault}, 8'd1);
    chk("fault_en", {7'd0, rail_if.en_vdd_1v8}, 8'd0);
    chk("fault_retry", {6'd0, rail_if.retry_count}, 8'd3);
    run_ticks(10);
    chk("fault_held", {7'd0, rail_if.rail_fault}, 8'd1);
    rail_if.power_on_req = 1'b0;
    step();
    step();
    chk("fault_clear", {7'd0, rail_if.rail_fault}, 8'd0);
    chk("fault_off", {5'd0, rail_if.seq_state}, 8'd0);

    // Reset in the middle of a ramp restarts the full timeout
    rail_if.power_on_req = 1'b1;
    run_ticks(30);
    reset = 1'b1;
    step();
    chk("midreset_state", {5'd0, rail_if.seq_state}, 8'd0);
    reset = 1'b0;
    step();
    chk("midreset_en", {7'd0, rail_if.en_vdd_1v8}, 8'd0);
    run_ticks(47);
    chk("fresh_timeout_ramp", {5'd0, rail_if.seq_state}, 8'd1);
    run_ticks(5);
    chk("fresh_timeout_dis", {5'd0, rail_if.seq_state}, 8'd3);
    chk("fresh_timeout_retry", {6'd0, rail_if.retry_count}, 8'd1);

    // Randomized request/PG activity with occasional reset
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        rail_if.pg_vdd_1v8_raw = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 40);
        if ($urandom_range(0, 9) == 0) rail_if.power_on_req = ~rail_if.power_on_req;
      end
      hold--;
      reset = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
